// File: rtl/ifu_prefetch_buf.sv
// Instruction prefetch buffer: fetches sequential words over a req/gnt/rvalid bus into a small FIFO.
// Latency: response to valid_o is one cycle (no bypass); request raised combinationally from registered state.
// Backpressure: ready_i=0 fills the FIFO; new requests stop once buffered plus live in-flight reaches DEPTH.
module ifu_prefetch_buf #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        err_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUTSTANDING);

    typedef enum logic {RUN, HALT} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic          held;        // request raised last cycle and not yet granted
    logic          held_stale;  // held request belongs to a flushed stream
    logic [31:0]   held_addr;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [31:0] mem_inst [DEPTH];
    logic [31:0] mem_pc   [DEPTH];
    logic        mem_err  [DEPTH];

    logic [CW:0]   in_use;
    logic          can_issue;
    logic          gnt;
    logic          rsp;
    logic          push;
    logic          pop;
    logic          gnt_drop;
    logic          halt_now;
    logic [CW-1:0] outstanding_n;

    // Slots already claimed: buffered entries plus responses that will still be kept.
    assign in_use    = {1'b0, count} + {1'b0, outstanding} - {1'b0, discard};
    assign can_issue = (state == RUN) && (outstanding < MAX_W) && (in_use < DEPTH_W);

    // A raised request stays up with a frozen address until the bus takes it.
    assign instr_req_o  = ~rst & (held | can_issue);
    assign instr_addr_o = held ? held_addr : fetch_pc;

    assign gnt = instr_req_o & instr_gnt_i;
    // Responses with nothing tracked in flight (e.g. straddling a reset) are ignored.
    assign rsp = instr_rvalid_i & (outstanding != '0);
    assign push = rsp & (discard == '0) & ~flush_i;
    assign pop  = valid_o & ready_i & ~flush_i;
    // Grants of a flushed held request, or of anything issued while halted, are never kept.
    assign gnt_drop = gnt & ((held & held_stale) | (state == HALT));
    assign halt_now = push & instr_err_i;
    assign outstanding_n = outstanding + CW'(gnt) - CW'(rsp);

    assign valid_o = (count != '0);
    assign inst_o  = valid_o ? mem_inst[rd_ptr] : 32'h0;
    assign pc_o    = valid_o ? mem_pc[rd_ptr]   : 32'h0;
    assign err_o   = valid_o ? mem_err[rd_ptr]  : 1'b0;

    // Fetch address generation and held-request tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            held       <= 1'b0;
            held_stale <= 1'b0;
            held_addr  <= RESET_PC;
        end else begin
            if (flush_i)
                fetch_pc <= flush_addr_i & ~32'h3;
            else if (gnt && !(held && held_stale))
                fetch_pc <= fetch_pc + 32'd4;
            held       <= instr_req_o & ~instr_gnt_i;
            held_addr  <= instr_addr_o;
            held_stale <= instr_req_o & ~instr_gnt_i & ((held & held_stale) | flush_i);
        end
    end

    // In-flight and to-be-dropped response counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_n;
            if (flush_i || halt_now)
                discard <= outstanding_n;
            else
                discard <= discard - CW'(rsp && (discard != '0)) + CW'(gnt_drop);
        end
    end

    // RUN/HALT state: an error entry stops fetching until a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else if (flush_i)
            state <= RUN;
        else if (halt_now)
            state <= HALT;
    end

    // FIFO occupancy and pointers; flush empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + CW'(push) - CW'(pop);
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(push);
        end
    end

    // Entry storage, written on each kept response.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= instr_rdata_i;
            mem_pc[wr_ptr]   <= held_pc_of_head();
            mem_err[wr_ptr]  <= instr_err_i;
        end
    end

    // Address of the oldest kept in-flight request, tracked in a small address queue.
    logic [31:0] aq [DEPTH];
    logic [PW-1:0] aq_wr;
    logic [PW-1:0] aq_rd;

    function automatic logic [31:0] held_pc_of_head();
        return aq[aq_rd];
    endfunction

    // Record every granted address in order; every response retires the oldest one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aq_wr <= '0;
            aq_rd <= '0;
        end else begin
            aq_wr <= aq_wr + PW'(gnt);
            aq_rd <= aq_rd + PW'(rsp);
        end
    end

    // Granted-address storage.
    always_ff @(posedge clk) begin
        if (gnt)
            aq[aq_wr] <= instr_addr_o;
    end

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
module tb_ifu_prefetch_buf;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam logic [31:0] RPC = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_addr_i = 32'h0;
    logic        instr_req_o;
    logic        instr_gnt_i = 1'b0;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = 32'h0;
    logic        instr_err_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        err_o;

    always #5 clk = ~clk;

    ifu_prefetch_buf #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
        .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
        .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o), .pc_o(pc_o), .err_o(err_o)
    );

    // ---------------- behavioural model ----------------
    typedef struct {logic [31:0] pc; bit drop;} fl_t;
    typedef struct {logic [31:0] inst; logic [31:0] pc; bit err;} ent_t;
    typedef struct {logic [31:0] pc; logic err;} pop_t;

    fl_t         inflight[$];
    ent_t        mfifo[$];
    bit          m_halt, m_held, m_held_drop;
    logic [31:0] m_pc = RPC, m_held_addr;

    // bus slave and observation
    logic [31:0] sq[$];
    pop_t        popped[$];

    int n_chk = 0, n_fail = 0;

    // stimulus knobs
    int  gnt_pct = 100, rv_pct = 100, ready_pct = 100, flush_pct = 0, err_pct = 0;
    logic [31:0] rv_limit = 32'hFFFFFFFF;
    bit  err_pc_en = 0;
    logic [31:0] err_pc = 32'h0;
    bit  fl_req = 0;
    logic [31:0] fl_addr = 32'h0;
    bit  d_rst = 1;
    bit  req_s;
    logic [31:0] addr_s;
    int  n_req = 0, n_addr_bad = 0;

    function automatic logic [31:0] hash(logic [31:0] a);
        return ~a ^ 32'h3C3C0F0F;
    endfunction

    function automatic bit m_req();
        int live = 0;
        if (m_held) return 1'b1;
        if (m_halt) return 1'b0;
        foreach (inflight[i]) if (!inflight[i].drop) live++;
        return (inflight.size() < MAXO) && (mfifo.size() + live < DEPTH);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_held ? m_held_addr : m_pc;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        if (rst) begin
            chk("rst_req", {31'b0, instr_req_o}, 32'h0);
            chk("rst_addr", instr_addr_o, RPC);
            chk("rst_valid", {31'b0, valid_o}, 32'h0);
            chk("rst_inst", inst_o, 32'h0);
            chk("rst_pc", pc_o, 32'h0);
            chk("rst_err", {31'b0, err_o}, 32'h0);
        end else begin
            bit er;
            er = m_req();
            chk("req", {31'b0, instr_req_o}, {31'b0, er});
            if (er) chk("addr", instr_addr_o, m_addr());
            chk("valid", {31'b0, valid_o}, {31'b0, mfifo.size() != 0});
            if (mfifo.size() != 0) begin
                chk("inst", inst_o, mfifo[0].inst);
                chk("pc", pc_o, mfifo[0].pc);
                chk("err", {31'b0, err_o}, {31'b0, mfifo[0].err});
            end
        end
    endtask

    task automatic m_update();
        bit req, cur_drop;
        logic [31:0] addr;
        fl_t f;
        ent_t e;
        if (rst) begin
            inflight.delete(); mfifo.delete();
            m_halt = 0; m_held = 0; m_held_drop = 0; m_pc = RPC;
            return;
        end
        req = m_req();
        addr = m_addr();
        cur_drop = m_held && m_held_drop;
        if (mfifo.size() != 0 && ready_i && !flush_i) void'(mfifo.pop_front());
        if (instr_rvalid_i && inflight.size() != 0) begin
            f = inflight.pop_front();
            if (!f.drop) begin
                e.inst = instr_rdata_i; e.pc = f.pc; e.err = instr_err_i;
                mfifo.push_back(e);
                if (instr_err_i) begin
                    m_halt = 1;
                    foreach (inflight[i]) inflight[i].drop = 1;
                end
            end
        end
        if (req && instr_gnt_i) begin
            f.pc = addr; f.drop = cur_drop || m_halt;
            inflight.push_back(f);
            if (!cur_drop) m_pc = m_pc + 32'd4;
        end
        if (req && !instr_gnt_i) begin
            m_held_drop = cur_drop || flush_i;
            m_held = 1; m_held_addr = addr;
        end else begin
            m_held = 0; m_held_drop = 0;
        end
        if (flush_i) begin
            mfifo.delete();
            foreach (inflight[i]) inflight[i].drop = 1;
            m_halt = 0;
            m_pc = flush_addr_i & ~32'h3;
        end
    endtask

    task automatic step();
        pop_t p;
        @(negedge clk);
        compare();
        rst = d_rst;
        flush_i = !d_rst && (fl_req || ($urandom_range(99) < flush_pct));
        flush_addr_i = fl_req ? fl_addr : $urandom;
        instr_gnt_i = $urandom_range(99) < gnt_pct;
        ready_i = $urandom_range(99) < ready_pct;
        instr_rvalid_i = 1'b0;
        instr_rdata_i = $urandom;
        instr_err_i = 1'b0;
        if (!d_rst && sq.size() != 0 && sq[0] < rv_limit && $urandom_range(99) < rv_pct) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i = hash(sq[0]);
            instr_err_i = (err_pc_en && sq[0] == err_pc) || ($urandom_range(99) < err_pct);
        end
        #1;
        req_s = instr_req_o;
        addr_s = instr_addr_o;
        if (req_s) n_req++;
        if (req_s && addr_s != 32'h0) n_addr_bad++;
        if (valid_o && ready_i && !flush_i && !rst) begin
            p.pc = pc_o; p.err = err_o;
            popped.push_back(p);
        end
        @(posedge clk);
        m_update();
        if (rst) sq.delete();
        else begin
            if (instr_rvalid_i) void'(sq.pop_front());
            if (req_s && instr_gnt_i) sq.push_back(addr_s);
        end
        fl_req = 0;
    endtask

    task automatic do_reset();
        d_rst = 1;
        repeat (3) step();
        d_rst = 0;
        gnt_pct = 100; rv_pct = 100; ready_pct = 100; flush_pct = 0; err_pct = 0;
        rv_limit = 32'hFFFFFFFF; err_pc_en = 0;
        popped.delete();
    endtask

    initial begin
        // Streaming: pcs 0,4,8,C and one instruction per cycle
        do_reset();
        repeat (10) step();
        chk("s1_pops", popped.size(), 8);
        chk("s1_pc0", popped[0].pc, 32'h0);
        chk("s1_pc1", popped[1].pc, 32'h4);
        chk("s1_pc2", popped[2].pc, 32'h8);
        chk("s1_pc3", popped[3].pc, 32'hC);

        // Backpressure: exactly four buffered, then drained in order
        do_reset();
        ready_pct = 0;
        repeat (10) step();
        chk("s2_req_stopped", {31'b0, req_s}, 32'h0);
        gnt_pct = 0; ready_pct = 100; popped.delete();
        repeat (6) step();
        chk("s2_pops", popped.size(), 4);
        chk("s2_pc0", popped[0].pc, 32'h0);
        chk("s2_pc3", popped[3].pc, 32'hC);
        chk("s2_resume_req", {31'b0, req_s}, 32'h1);
        chk("s2_resume_addr", addr_s, 32'h10);

        // Flush with 8 and C outstanding
        do_reset();
        rv_limit = 32'h8;
        repeat (8) step();
        chk("s3_prepops", popped.size(), 2);
        rv_limit = 32'hFFFFFFFF; fl_req = 1; fl_addr = 32'h100; popped.delete();
        repeat (7) step();
        chk("s3_after_flush_nonempty", {31'b0, popped.size() != 0}, 32'h1);
        chk("s3_first_pc", popped[0].pc, 32'h100);

        // Bus error on pc 4 halts fetching until flush
        do_reset();
        err_pc_en = 1; err_pc = 32'h4;
        repeat (3) step();
        n_req = 0;
        repeat (6) step();
        chk("s4_no_req", n_req, 0);
        chk("s4_pops", popped.size(), 2);
        chk("s4_pc1", popped[1].pc, 32'h4);
        chk("s4_err1", {31'b0, popped[1].err}, 32'h1);
        chk("s4_err0", {31'b0, popped[0].err}, 32'h0);
        err_pc_en = 0; fl_req = 1; fl_addr = 32'h200; popped.delete();
        repeat (7) step();
        chk("s4_flush_pc", popped[0].pc, 32'h200);

        // Stalled grant across a flush keeps the address stable
        do_reset();
        gnt_pct = 0; n_req = 0; n_addr_bad = 0;
        step();
        fl_req = 1; fl_addr = 32'h303;
        repeat (4) step();
        chk("s5_req_held", n_req, 5);
        chk("s5_addr_stable", n_addr_bad, 0);
        gnt_pct = 100; popped.delete();
        repeat (6) step();
        chk("s5_first_pc", popped[0].pc, 32'h300);

        // Address wrap
        do_reset();
        fl_req = 1; fl_addr = 32'hFFFFFFF8;
        repeat (10) step();
        chk("s6_pops_ge4", {31'b0, popped.size() >= 4}, 32'h1);
        chk("s6_pc0", popped[0].pc, 32'hFFFFFFF8);
        chk("s6_pc1", popped[1].pc, 32'hFFFFFFFC);
        chk("s6_pc2", popped[2].pc, 32'h0);
        chk("s6_pc3", popped[3].pc, 32'h4);

        // Randomized traffic against the model
        do_reset();
        gnt_pct = 60; rv_pct = 50; ready_pct = 60; flush_pct = 3; err_pct = 3;
        for (int i = 0; i < 3000; i++) begin
            d_rst = ($urandom_range(499) == 0);
            if (i == 1500) begin gnt_pct = 90; rv_pct = 85; ready_pct = 30; end
            step();
        end
        d_rst = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch_buf.md
IFU_PREFETCH_BUF -- requirements
Module: ifu_prefetch_buf

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-002 Parameter MAX_OUTSTANDING, default 2: granted-but-unanswered bus requests allowed, 1..DEPTH.
REQ-003 Parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 flush_i  in  1  discard buffered/in-flight instructions and redirect fetch.
REQ-007 flush_addr_i  in  32  new fetch address, sampled when flush_i=1.
REQ-008 instr_req_o  out  1  bus request.
REQ-009 instr_gnt_i  in  1  bus grant; request accepted when instr_req_o & instr_gnt_i.
REQ-010 instr_addr_o  out  32  word-aligned fetch address.
REQ-011 instr_rvalid_i  in  1  response valid, in order, at least one cycle after grant.
REQ-012 instr_rdata_i  in  32  response data.
REQ-013 instr_err_i  in  1  response error, qualified by instr_rvalid_i.
REQ-014 valid_o  out  1  head FIFO entry available.
REQ-015 ready_i  in  1  consumer accepts head when valid_o & ready_i.
REQ-016 inst_o / pc_o  out  32 / 32  head instruction and its address.
REQ-017 err_o  out  1  head entry carries bus error.

Function
REQ-018 States: RUN (fetching), HALT (error entry buffered; no new requests).
REQ-019 Counters: fetch_pc (32b), outstanding (0..MAX_OUTSTANDING), discard (0..MAX_OUTSTANDING), fifo count (0..DEPTH).
REQ-020 instr_req_o=1 in RUN when outstanding < MAX_OUTSTANDING and count+outstanding-discard < DEPTH; also held high until granted once raised.
REQ-021 While instr_req_o=1 and instr_gnt_i=0, instr_addr_o and instr_req_o stay stable, including across flush_i.
REQ-022 On grant: fetch_pc += 4 (wraps 32'hFFFFFFFC to 0), outstanding += 1.
REQ-023 Each entry's pc equals the address it was granted at; pc_o tracks the head entry.
REQ-024 On rvalid with discard=0: push {rdata, pc, err}, outstanding -= 1; if err=1, state -> HALT.
REQ-025 On rvalid with discard>0: drop response, discard -= 1, outstanding -= 1.
REQ-026 Same-cycle grant and rvalid: outstanding unchanged.
REQ-027 Same-cycle push and pop with FIFO full: both occur; count unchanged.
REQ-028 Pop with empty FIFO never occurs; valid_o=0 when count=0; no rdata bypass (minimum latency rvalid -> valid_o is 1 cycle).
REQ-029 FIFO never overflows: REQ-020 reserves a slot for every counted in-flight response.
REQ-030 flush_i=1: next cycle FIFO empty, valid_o=0, fetch_pc=flush_addr_i & ~3, state RUN, discard = outstanding after this cycle's grant/rvalid updates.
REQ-031 flush_i with ready_i same cycle: pop ignored; flush wins.
REQ-032 Request pending ungranted at flush (REQ-021): on grant it is counted in discard; fetch_pc is not incremented; the next request uses flush_addr_i.
REQ-033 Flush with pending grant plus further flush before completion: discard accumulates; ordering preserved.
REQ-034 HALT: instr_req_o=0 except a request already held per REQ-021 (its response is dropped); leaves HALT only on flush_i or reset.
REQ-035 flush_addr_i[1:0] ignored.

Reset
REQ-036 While rst=1: instr_req_o=0, instr_addr_o=RESET_PC, valid_o=0, inst_o=0, pc_o=0, err_o=0, all counters 0, state RUN.
REQ-037 First request raised in the first cycle after rst deasserts, at RESET_PC.
REQ-038 Reset mid-transaction: in-flight responses arriving after reset are not tracked; system resets bus slave concurrently.

Verification
REQ-039 Reset release, gnt=1 always, rvalid one cycle after grant, ready=1 -> pc_o sequence 0,4,8,C; one instruction per cycle steady state.
REQ-040 ready=0, DEPTH=4 -> exactly 4 entries buffered, instr_req_o stays 0 thereafter; ready=1 -> 4 pops in order, fetching resumes.
REQ-041 Two outstanding (pc 8,C), flush_i with flush_addr_i=32'h100 -> both responses dropped; next valid_o shows pc_o=32'h100.
REQ-042 Response for pc 4 with instr_err_i=1 -> entry pc_o=4, err_o=1; no further requests until flush_i to 32'h200.
REQ-043 instr_gnt_i held 0 for 5 cycles with flush_i in cycle 2 -> instr_addr_o stable; granted response discarded; next fetch at flush address.
REQ-044 fetch_pc=32'hFFFFFFFC granted -> next request at 32'h00000000.
